// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: FSM state encodings and counter-width helper
package serial_subtractor_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: one-bit gate-level subtractor cell (a, b, bin -> d = a^b^bin, bout = ~a&b | ~(a^b)&bin)
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic axb, na, nx, t0, t1;
  xor g0 (axb, a, b);
  xor g1 (d, axb, bin);
  not g2 (na, a);
  and g3 (t0, na, b);
  not g4 (nx, axb);
  and g5 (t1, nx, bin);
  or  g6 (bout, t0, t1);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a-b, one bit per clk; start in, busy/done/diff/borrow/ovf out, sync active-low rst_n
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);
  localparam int CW = clog2(WIDTH);
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic borrow_reg, a_msb, b_msb, d, bout;
  full_subtractor u_fs (
    .a(a_sh[0]),
    .b(b_sh[0]),
    .bin(borrow_reg),
    .d(d),
    .bout(bout)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      a_sh <= '0;
      b_sh <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      borrow_reg <= 1'b0;
      diff <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        a_sh <= a;
        b_sh <= b;
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
        borrow_reg <= 1'b0;
        diff <= '0;
        cnt <= '0;
        state <= SHIFT;
      end
    end else if (state == SHIFT) begin
      diff <= {d, diff[WIDTH-1:1]};
      borrow_reg <= bout;
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      cnt <= cnt + 1'b1;
      state <= (cnt == CW'(WIDTH - 1)) ? DONE : SHIFT;
    end else begin
      state <= IDLE;
    end
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign borrow = borrow_reg;
  assign ovf = (a_msb ^ b_msb) & (diff[WIDTH-1] ^ a_msb);
endmodule
